load_data_ctr: RTL

//  Load-side counterpart of the store byte-enable logic in the MEM stage.
//  - Accepts one load (LB/LBU/LH/LHU/LW) per request, tracks memory/IO read latency and stalls the pipeline.
//  - Selects the addressed byte/halfword (big-endian: offset 0 = bits [31:24]), zero/sign-extends it and returns one registered 32-bit word.

---
 rtl/load_data_ctr_pkg.sv | 46 ++++
 rtl/load_data_ctr_align.sv | 37 +++
 rtl/load_data_ctr.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/load_data_ctr_pkg.sv
// Shared load-side definitions: opcode encodings, address regions, FSM states.
package load_data_ctr_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SW  = 6'h2b;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_DMEM,
        REG_IO
    } region_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DMEM_WAIT,
        S_IO_WAIT,
        S_DONE
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    // DMEM = 4'b0zz1, IO = 4'b1zzz
    function automatic region_t region_of(input logic [3:0] top);
        if (top[3])
            return REG_IO;
        else if (top[0])
            return REG_DMEM;
        else
            return REG_NONE;
    endfunction

    function automatic logic misaligned(input logic [5:0] op,
                                        input logic [1:0] off);
        return (((op == OP_LH) || (op == OP_LHU)) && off[0]) ||
               ((op == OP_LW) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_data_ctr_align.sv
// Big-endian byte/halfword select with zero/sign extension.
module load_align
    import load_data_ctr_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        bsel = 8'h00;
        unique case (offset)
            2'd0: bsel = word[31:24];
            2'd1: bsel = word[23:16];
            2'd2: bsel = word[15:8];
            2'd3: bsel = word[7:0];
            default: bsel = 8'h00;
        endcase
        hsel = offset[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        result = word;
        unique case (1'b1)
            (opcode == OP_LB):  result = {{24{bsel[7]}}, bsel};
            (opcode == OP_LBU): result = {24'h0, bsel};
            (opcode == OP_LH):  result = {{16{hsel[15]}}, hsel};
            (opcode == OP_LHU): result = {16'h0, hsel};
            default:            result = word;
        endcase
    end

endmodule

// File: rtl/load_data_ctr.sv
// MEM-stage load controller: latency tracking, stall, aligned registered result.
// Optional LOAD_MISALIGN_TRAP_EN adds the load_misalign flag and zeroes bad loads.
module load_data_ctr
    import load_data_ctr_pkg::*;
#(
    parameter int DMEM_LATENCY = 1,
    parameter int IO_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] dmem_rdata,
    input  logic [31:0] io_rdata,
    input  logic        io_ready,
    output logic        io_req,
    output logic        stall,
    output logic        load_valid,
`ifdef LOAD_MISALIGN_TRAP_EN
    output logic        load_misalign,
`endif
    output logic [31:0] load_data
);

    localparam logic [7:0] DM_LAST = 8'(DMEM_LATENCY - 1);
    localparam logic [7:0] IO_LAST = 8'(IO_TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic        accept;
    logic        sample;
    logic [31:0] word_n;
    logic [5:0]  al_op;
    logic [1:0]  al_off;
    logic [31:0] al_res;
    logic        unused_addr;

    assign unused_addr = ^addr[27:2];
    assign accept = req_valid && (state == S_IDLE) && is_load(opcode);

    // Zero-latency NONE loads align straight off the request inputs.
    assign al_op  = (state == S_IDLE) ? opcode : op_q;
    assign al_off = (state == S_IDLE) ? addr[1:0] : off_q;

    load_align u_align (
        .opcode (al_op),
        .offset (al_off),
        .word   (word_n),
        .result (al_res)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sample  = 1'b0;
        word_n  = 32'h0;
        unique case (state)
            S_IDLE: begin
                cnt_n = 8'h0;
                if (accept) begin
                    unique case (region_of(addr[31:28]))
                        REG_DMEM: state_n = S_DMEM_WAIT;
                        REG_IO:   state_n = S_IO_WAIT;
                        default: begin
                            state_n = S_DONE;
                            sample  = 1'b1;
                        end
                    endcase
                end
            end
            S_DMEM_WAIT: begin
                if (cnt == DM_LAST) begin
                    state_n = S_DONE;
                    sample  = 1'b1;
                    word_n  = dmem_rdata;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_IO_WAIT: begin
                if (io_ready) begin
                    state_n = S_DONE;
                    sample  = 1'b1;
                    word_n  = io_rdata;
                end else if (cnt == IO_LAST) begin
                    state_n = S_DONE;
                    sample  = 1'b1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 8'h0;
            op_q  <= 6'h0;
            off_q <= 2'b00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                op_q  <= opcode;
                off_q <= addr[1:0];
            end
        end
    end

`ifdef LOAD_MISALIGN_TRAP_EN
    logic mis;
    assign mis = misaligned(al_op, al_off);

    always_ff @(posedge clk) begin
        if (rst) begin
            load_data     <= 32'h0;
            load_misalign <= 1'b0;
        end else begin
            load_misalign <= sample && mis;
            if (sample)
                load_data <= mis ? 32'h0 : al_res;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst)
            load_data <= 32'h0;
        else if (sample)
            load_data <= al_res;
    end
`endif

    assign io_req     = (state == S_IO_WAIT);
    assign load_valid = (state == S_DONE);
    assign stall      = (state == S_DMEM_WAIT) || (state == S_IO_WAIT) || accept;

endmodule
